stepper_phase_monitor: RTL and testbench
========================================

// Module: stepper_phase_monitor
// PURPOSE
//  Receive-side monitor for the 4-phase stepper drive bus produced by the motor driver FSM.
//  - Samples motor_drv every drv_clk.
//  - Decodes direction and counts full steps into a signed, wrapping position register.
//  - Flags illegal codes and skipped phases.
//  - Reports when the shaft has settled.
//  - Sits beside the motor driver on the same clock and feeds closed-loop position checks.
// PARAMETERS
//  POS_W     16  width of the position counter (two's complement, wraps modulo 2^POS_W)
//  SETTLE_N   8  consecutive unchanged-phase cycles in TRACK before settled asserts (>=1)
// PORTS
//  drv_clk    in   1      clock; all state updates on its rising edge
//  reset      in   1      asynchronous reset, active-low
//  motor_drv  in   4      phase bus from the driver; legal codes 0000, 0001, 0010, 0100, 1000
//  pos_clr    in   1      synchronous clear of pos to 0
//  clr_err    in   1      synchronous clear of err; FAULT -> IDLE
//  pos        out  POS_W  current step position
//  dir        out  1      direction of the last counted step: 1 = forward, 0 = reverse
//  step       out  1      one-cycle pulse per counted step
//  settled    out  1      level: phase unchanged for SETTLE_N cycles while in TRACK
//  err        out  1      sticky fault flag
//  trk_st     out  2      FSM state: 00 IDLE, 01 TRACK, 10 FAULT
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//  - state=IDLE; prev=0000; pos=0; dir=1; step=0; settled=0; err=0; settle counter=0.
//  - Outputs are held at these values for as long as reset is low.
//  Sequencing:
//  - prev register holds motor_drv from the previous edge.
//  - Decode compares motor_drv (now) with prev.
//  - All outputs are registered: an event sampled at edge N is visible after edge N.
//  Phase order:
//  - Forward: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
//  - Reverse is the exact opposite order.
//  IDLE:
//  - Legal nonzero code -> TRACK. This is the reference phase only: no step, pos unchanged.
//  - 0000 -> stay in IDLE.
//  - Illegal code -> FAULT.
//  TRACK (checks in this order):
//  - Illegal code -> FAULT; err=1.
//  - 0000 -> IDLE; pos and dir held; settled=0.
//  - motor_drv == prev -> hold; settle counter increments, saturating at SETTLE_N;
//    settled=1 when the counter reaches SETTLE_N.
//  - Forward neighbour of prev -> pos=pos+1; dir=1; step=1; settle counter=0; settled=0.
//  - Reverse neighbour of prev -> pos=pos-1; dir=0; step=1; settle counter=0; settled=0.
//  - Opposite phase (skip by two, e.g. 0001 -> 0100) -> FAULT; err=1; pos unchanged.
//  FAULT:
//  - pos, dir frozen; step=0; settled=0.
//  - clr_err=1 -> IDLE with err=0; the next legal code re-acquires the reference phase.
//  Wrap-around:
//  - pos wraps 7FFF->8000 forward and 8000->7FFF reverse (POS_W=16). No saturation, no flag.
//  Simultaneous events:
//  - pos_clr and a counted step in the same cycle: pos=0, but step and dir still reflect the
//    step.
//  - pos_clr is honoured in every state.
//  - clr_err together with a fault condition (in TRACK or IDLE): the fault wins; err stays 1.
//  - clr_err outside FAULT: no effect.
//  Reset mid-operation:
//  - Immediate return to the reset values, including pos=0.
//  - The first code after reset release is treated as a reference phase, never as a step.
// TESTING
//  1. Reset -> 0001, 0010, 0100, 1000, 0001 (one per cycle) -> 4 step pulses, pos=4, dir=1,
//     trk_st=01.
//  2. From pos=4 at phase 0001: 1000, 0100 -> pos=2, dir=0; then hold 0100 for 8 cycles ->
//     settled=1 on the 8th hold edge, 0 on the next step.
//  3. TRACK at 0001, then apply 0100 -> err=1, trk_st=10, pos unchanged; clr_err -> err=0,
//     trk_st=00.
//  4. Apply 0011 in IDLE and in TRACK -> FAULT, err=1, no step pulse.
//  5. pos=16'h7FFF, forward step -> pos=16'h8000; reverse step -> 16'h7FFF;
//     pos_clr with a step -> pos=0, step=1.
//  6. reset low mid-run at pos=5 -> all outputs reset; release, apply 0100 then 1000 ->
//     exactly one step, pos=1.

Source files
------------

// File: rtl/stepper_phase_monitor.sv
// Receive-side monitor for a 4-phase stepper drive bus: tracks phase order into a signed,
// wrapping step position and flags illegal codes, skipped phases and shaft settling.
module stepper_phase_monitor #(
   parameter int POS_W    = 16,
   parameter int SETTLE_N = 8
) (
   input  logic             drv_clk,
   input  logic             reset,
   input  logic [3:0]       motor_drv,
   input  logic             pos_clr,
   input  logic             clr_err,
   output logic [POS_W-1:0] pos,
   output logic             dir,
   output logic             step,
   output logic             settled,
   output logic             err,
   output logic [1:0]       trk_st
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TRACK = 2'b01,
      ST_FAULT = 2'b10
   } state_t;

   localparam int                CNT_W      = $clog2(SETTLE_N + 1);
   localparam logic [CNT_W-1:0]  SETTLE_CNT = CNT_W'(SETTLE_N);

   state_t           state_q;
   logic [3:0]       prev_q;
   logic [POS_W-1:0] pos_q;
   logic             dir_q;
   logic             step_q;
   logic             settled_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             legal;
   logic             is_fwd;
   logic             is_rev;
   logic [CNT_W-1:0] cnt_d;

   // Phases are one-hot, so the forward neighbour is a left rotate and reverse a right rotate.
   always_comb begin
      legal  = $onehot0(motor_drv);
      is_fwd = (motor_drv == {prev_q[2:0], prev_q[3]});
      is_rev = (motor_drv == {prev_q[0], prev_q[3:1]});
      cnt_d  = (cnt_q == SETTLE_CNT) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only; the later pos_clr assignment
   // deliberately overrides any step update made earlier in the same edge.
   always_ff @(posedge drv_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         prev_q    <= 4'b0000;
         pos_q     <= '0;
         dir_q     <= 1'b1;
         step_q    <= 1'b0;
         settled_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         prev_q <= motor_drv;
         step_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               settled_q <= 1'b0;
               cnt_q     <= '0;
               if (!legal) begin
                  state_q <= ST_FAULT;
                  err_q   <= 1'b1;
               end else if (motor_drv != 4'b0000) begin
                  state_q <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (legal && motor_drv == 4'b0000) begin
                  state_q   <= ST_IDLE;
                  settled_q <= 1'b0;
                  cnt_q     <= '0;
               end else if (legal && motor_drv == prev_q) begin
                  cnt_q     <= cnt_d;
                  settled_q <= (cnt_d == SETTLE_CNT);
               end else if (legal && (is_fwd || is_rev)) begin
                  pos_q     <= is_fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  dir_q     <= is_fwd;
                  step_q    <= 1'b1;
                  settled_q <= 1'b0;
                  cnt_q     <= '0;
               end else begin
                  // Illegal code or a skipped (opposite) phase.
                  state_q   <= ST_FAULT;
                  err_q     <= 1'b1;
                  settled_q <= 1'b0;
                  cnt_q     <= '0;
               end
            end
            ST_FAULT: begin
               settled_q <= 1'b0;
               cnt_q     <= '0;
               if (clr_err) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (pos_clr) pos_q <= '0;
      end
   end

   assign pos     = pos_q;
   assign dir     = dir_q;
   assign step    = step_q;
   assign settled = settled_q;
   assign err     = err_q;
   assign trk_st  = state_q;

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Self-checking bench for stepper_phase_monitor: directed scenarios plus randomized phase
// traffic compared against a phase-index reference model.
module tb_stepper_phase_monitor;

   localparam int POS_W    = 16;
   localparam int SETTLE_N = 8;
   localparam int M_IDLE = 0, M_TRACK = 1, M_FAULT = 2;

   logic             drv_clk = 1'b0;
   logic             reset;
   logic [3:0]       motor_drv;
   logic             pos_clr;
   logic             clr_err;
   logic [POS_W-1:0] pos;
   logic             dir, step, settled, err;
   logic [1:0]       trk_st;

   int checks = 0;
   int errors = 0;

   logic [3:0] phase_code [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   // Reference model state
   int               m_state;
   logic [3:0]       m_prev;
   logic [POS_W-1:0] m_pos;
   logic             m_dir, m_step, m_settled, m_err;
   int               m_cnt;

   stepper_phase_monitor #(.POS_W(POS_W), .SETTLE_N(SETTLE_N)) dut (
      .drv_clk  (drv_clk),
      .reset    (reset),
      .motor_drv(motor_drv),
      .pos_clr  (pos_clr),
      .clr_err  (clr_err),
      .pos      (pos),
      .dir      (dir),
      .step     (step),
      .settled  (settled),
      .err      (err),
      .trk_st   (trk_st)
   );

   always #5 drv_clk = ~drv_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Phase index 0..3 of a one-hot code, -1 for 0000, -2 for anything illegal.
   function automatic int phase_idx(input logic [3:0] c);
      if (c == 4'b0000) return -1;
      for (int i = 0; i < 4; i++) if (c == phase_code[i]) return i;
      return -2;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_prev = 4'b0000; m_pos = '0; m_dir = 1'b1;
      m_step = 1'b0; m_settled = 1'b0; m_err = 1'b0; m_cnt = 0;
   endtask

   task automatic model_fault();
      m_state = M_FAULT; m_err = 1'b1; m_settled = 1'b0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic [3:0] code, input logic pc, input logic ce);
      int ni, pi, d;
      ni = phase_idx(code);
      pi = phase_idx(m_prev);
      m_step = 1'b0;
      case (m_state)
         M_IDLE: begin
            m_settled = 1'b0; m_cnt = 0;
            if (ni == -2) model_fault();
            else if (ni >= 0) m_state = M_TRACK;
         end
         M_TRACK: begin
            if (ni == -2) model_fault();
            else if (ni == -1) begin
               m_state = M_IDLE; m_settled = 1'b0; m_cnt = 0;
            end else begin
               d = (ni - pi + 4) % 4;
               if (d == 0) begin
                  if (m_cnt < SETTLE_N) m_cnt++;
                  m_settled = (m_cnt == SETTLE_N);
               end else if (d == 1 || d == 3) begin
                  m_pos = (d == 1) ? m_pos + 1'b1 : m_pos - 1'b1;
                  m_dir = (d == 1);
                  m_step = 1'b1; m_settled = 1'b0; m_cnt = 0;
               end else model_fault();
            end
         end
         default: begin
            m_settled = 1'b0; m_cnt = 0;
            if (ce) begin m_state = M_IDLE; m_err = 1'b0; end
         end
      endcase
      if (pc) m_pos = '0;
      m_prev = code;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".pos"},     32'(pos),     32'(m_pos));
      check({tag, ".dir"},     32'(dir),     32'(m_dir));
      check({tag, ".step"},    32'(step),    32'(m_step));
      check({tag, ".settled"}, 32'(settled), 32'(m_settled));
      check({tag, ".err"},     32'(err),     32'(m_err));
      check({tag, ".trk_st"},  32'(trk_st),  32'(m_state));
   endtask

   task automatic cycle(input logic [3:0] code, input logic pc = 1'b0, input logic ce = 1'b0,
                        input bit chk = 1'b1);
      motor_drv = code; pos_clr = pc; clr_err = ce;
      @(posedge drv_clk);
      model_edge(code, pc, ce);
      #1;
      if (chk) check_outputs("cyc");
   endtask

   task automatic do_reset();
      @(negedge drv_clk);
      #2 reset = 1'b0;
      model_reset();
      #1 check_outputs("rst");
      @(posedge drv_clk);
      #1 check_outputs("rst_hold");
      @(negedge drv_clk);
      reset = 1'b1;
   endtask

   function automatic logic [3:0] pick_code();
      int cur, r;
      cur = phase_idx(m_prev);
      if (cur < 0) cur = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 30)      return phase_code[(cur + 1) % 4];
      else if (r < 55) return phase_code[(cur + 3) % 4];
      else if (r < 78) return phase_code[cur];
      else if (r < 83) return 4'b0000;
      else if (r < 87) return phase_code[(cur + 2) % 4];
      else if (r < 92) return 4'($urandom_range(0, 15));
      else             return phase_code[$urandom_range(0, 3)];
   endfunction

   initial begin
      int nsteps;
      motor_drv = 4'b0000; pos_clr = 1'b0; clr_err = 1'b0; reset = 1'b1;
      model_reset();
      do_reset();

      // Forward sweep from reset: reference phase then four steps.
      nsteps = 0;
      foreach (phase_code[i]) begin
         cycle(phase_code[i]);
         if (step === 1'b1) nsteps++;
      end
      cycle(4'b0001);
      if (step === 1'b1) nsteps++;
      check("t1.steps", 32'(nsteps), 32'd4);
      check("t1.pos", 32'(pos), 32'd4);
      check("t1.trk", 32'(trk_st), 32'd1);

      // Reverse two steps, then settle.
      cycle(4'b1000);
      cycle(4'b0100);
      check("t2.pos", 32'(pos), 32'd2);
      check("t2.dir", 32'(dir), 32'd0);
      for (int i = 0; i < SETTLE_N; i++) begin
         cycle(4'b0100);
         check("t2.settle", 32'(settled), 32'(i == SETTLE_N - 1));
      end
      cycle(4'b0010);
      check("t2.unsettle", 32'(settled), 32'd0);

      // Skipped phase faults, clr_err recovers.
      cycle(4'b0001);
      cycle(4'b0100);
      check("t3.err", 32'(err), 32'd1);
      check("t3.trk", 32'(trk_st), 32'd2);
      check("t3.pos", 32'(pos), 32'd0);
      cycle(4'b0100, 1'b0, 1'b1);
      check("t3.clr_err", 32'(err), 32'd0);
      check("t3.clr_trk", 32'(trk_st), 32'd0);

      // Illegal code in IDLE and in TRACK; clr_err together with a fault loses.
      cycle(4'b0011);
      check("t4.idle_err", 32'(err), 32'd1);
      cycle(4'b0000, 1'b0, 1'b1);
      cycle(4'b0001);
      cycle(4'b0011, 1'b0, 1'b1);
      check("t4.trk_err", 32'(err), 32'd1);
      check("t4.no_step", 32'(step), 32'd0);
      cycle(4'b0000, 1'b0, 1'b1);

      // Wrap-around at the signed boundary, and pos_clr coinciding with a step.
      do_reset();
      cycle(4'b0001);
      for (int i = 0; i < 32767; i++) cycle(phase_code[(phase_idx(m_prev) + 1) % 4], 1'b0, 1'b0, 1'b0);
      check("t5.max", 32'(pos), 32'h7FFF);
      cycle(phase_code[(phase_idx(m_prev) + 1) % 4]);
      check("t5.wrap_fwd", 32'(pos), 32'h8000);
      cycle(phase_code[(phase_idx(m_prev) + 3) % 4]);
      check("t5.wrap_rev", 32'(pos), 32'h7FFF);
      cycle(phase_code[(phase_idx(m_prev) + 1) % 4], 1'b1);
      check("t5.clr_pos", 32'(pos), 32'd0);
      check("t5.clr_step", 32'(step), 32'd1);

      // Reset mid-run, then the first code is a reference phase only.
      do_reset();
      cycle(4'b0001);
      for (int i = 0; i < 5; i++) cycle(phase_code[(phase_idx(m_prev) + 1) % 4]);
      check("t6.pos5", 32'(pos), 32'd5);
      do_reset();
      cycle(4'b0100);
      check("t6.ref", 32'(step), 32'd0);
      cycle(4'b1000);
      check("t6.pos1", 32'(pos), 32'd1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else if ($urandom_range(0, 99) < 3) begin
            for (int k = 0; k < SETTLE_N + 2; k++) cycle(m_prev);
         end else begin
            cycle(pick_code(), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 15));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
